// File: rtl/redun_mul_folded_pkg.sv
// Shared width helpers and FSM encoding for the folded redundant multiplier.
package redun_mul_pkg;

    function automatic int mul_out_bit_len(input int a_bit_len);
        return 2 * a_bit_len;
    endfunction

    function automatic int acc_bit_len(input int a_bit_len, input int word_len,
                                       input int num_elements);
        return mul_out_bit_len(a_bit_len) - word_len + $clog2(2 * num_elements) + 1;
    endfunction

    function automatic int out_bit_len(input int a_bit_len, input int word_len,
                                       input int num_elements);
        return acc_bit_len(a_bit_len, word_len, num_elements) - word_len + 1 + word_len;
    endfunction

    function automatic int num_passes(input int num_elements, input int rows_per_cycle);
        return (num_elements + rows_per_cycle - 1) / rows_per_cycle;
    endfunction

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        NORM,
        DONE
    } state_t;

endpackage

// File: rtl/redun_mul_folded_mul_row.sv
// R x N multiplier array: picks the R rows of A for the current pass and
// registers every row-by-B[j] product.
module mul_row
    import redun_mul_pkg::*;
#(
    parameter int NUM_ELEMENTS    = 33,
    parameter int A_BIT_LEN       = 17,
    parameter int ROWS_PER_CYCLE  = 4,
    parameter int PASS_W          = 4,
    parameter int MUL_OUT_BIT_LEN = mul_out_bit_len(A_BIT_LEN)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_vld,
    input  logic [PASS_W-1:0]          pass,
    input  logic [A_BIT_LEN-1:0]       a [NUM_ELEMENTS],
    input  logic [A_BIT_LEN-1:0]       b [NUM_ELEMENTS],
    output logic                       vld_p0,
    output logic [PASS_W-1:0]          pass_p0,
    output logic [MUL_OUT_BIT_LEN-1:0] prod_p0 [ROWS_PER_CYCLE][NUM_ELEMENTS]
);

    logic [A_BIT_LEN-1:0] a_sel [ROWS_PER_CYCLE];

    // Rows past the last element select nothing and so multiply as zero.
    always_comb begin
        for (int r = 0; r < ROWS_PER_CYCLE; r++) begin
            a_sel[r] = '0;
            for (int i = 0; i < NUM_ELEMENTS; i++) begin
                if (i == int'(pass) * ROWS_PER_CYCLE + r) begin
                    a_sel[r] = a[i];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p0 <= 1'b0;
        end else begin
            vld_p0 <= in_vld;
        end
    end

    // Stage p0: registered partial products tagged with their pass index.
    always_ff @(posedge clk) begin
        pass_p0 <= pass;
        for (int r = 0; r < ROWS_PER_CYCLE; r++) begin
            for (int j = 0; j < NUM_ELEMENTS; j++) begin
                prod_p0[r][j] <= MUL_OUT_BIT_LEN'(a_sel[r]) * MUL_OUT_BIT_LEN'(b[j]);
            end
        end
    end

endmodule

// File: rtl/redun_mul_folded.sv
// Time-folded redundant multiplier/squarer: R rows of A per pass, column
// accumulation, one normalisation step, valid/ready result delivery.
module redun_mul_folded
    import redun_mul_pkg::*;
#(
    parameter int NUM_ELEMENTS   = 33,
    parameter int A_BIT_LEN      = 17,
    parameter int WORD_LEN       = 16,
    parameter int ROWS_PER_CYCLE = 4,
    localparam int MUL_OUT_BIT_LEN = mul_out_bit_len(A_BIT_LEN),
    localparam int ACC_BIT_LEN     = acc_bit_len(A_BIT_LEN, WORD_LEN, NUM_ELEMENTS),
    localparam int OUT_BIT_LEN     = out_bit_len(A_BIT_LEN, WORD_LEN, NUM_ELEMENTS),
    localparam int NUM_PASSES      = num_passes(NUM_ELEMENTS, ROWS_PER_CYCLE)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_square,
    input  logic [A_BIT_LEN-1:0]   A [NUM_ELEMENTS],
    input  logic [A_BIT_LEN-1:0]   B [NUM_ELEMENTS],
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OUT_BIT_LEN-1:0] out [2*NUM_ELEMENTS]
);

    localparam int NCOL   = 2 * NUM_ELEMENTS;
    localparam int PCOL   = ROWS_PER_CYCLE + NUM_ELEMENTS;
    localparam int PASS_W = $clog2(NUM_PASSES + 1);

    state_t                     state_q, state_d;
    logic [PASS_W-1:0]          pass_q, pass_d;
    logic                       accept, mul_vld, vld_p0;
    logic [PASS_W-1:0]          pass_p0;
    logic [A_BIT_LEN-1:0]       a_lat [NUM_ELEMENTS];
    logic [A_BIT_LEN-1:0]       b_lat [NUM_ELEMENTS];
    logic [MUL_OUT_BIT_LEN-1:0] prod_p0 [ROWS_PER_CYCLE][NUM_ELEMENTS];
    logic [ACC_BIT_LEN-1:0]     part [PCOL];
    logic [ACC_BIT_LEN-1:0]     acc_q [NCOL];
    logic [ACC_BIT_LEN-1:0]     acc_d [NCOL];
    logic [OUT_BIT_LEN-1:0]     norm [NCOL];

    // The top column keeps its full accumulator: the high half of the last
    // diagonal product lands there, and dropping it would lose value.
    function automatic logic [OUT_BIT_LEN-1:0] norm_elem(
        input logic [ACC_BIT_LEN-1:0] cur,
        input logic [ACC_BIT_LEN-1:0] prev,
        input logic                   keep_all
    );
        logic [OUT_BIT_LEN-1:0] body;
        body = keep_all ? OUT_BIT_LEN'(cur) : OUT_BIT_LEN'(cur[WORD_LEN-1:0]);
        return body + OUT_BIT_LEN'(prev[ACC_BIT_LEN-1:WORD_LEN]);
    endfunction

    assign in_ready = (state_q == IDLE);
    assign accept   = in_valid && in_ready;
    assign mul_vld  = (state_q == MUL) && (pass_q != PASS_W'(NUM_PASSES));

    // MUL lasts one extra cycle so the final products drain into the columns.
    always_comb begin
        state_d = state_q;
        pass_d  = pass_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = MUL;
                    pass_d  = '0;
                end
            end
            MUL: begin
                if (pass_q == PASS_W'(NUM_PASSES)) begin
                    state_d = NORM;
                    pass_d  = '0;
                end else begin
                    pass_d = pass_q + PASS_W'(1);
                end
            end
            NORM: state_d = DONE;
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pass_q  <= '0;
        end else begin
            state_q <= state_d;
            pass_q  <= pass_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < NUM_ELEMENTS; i++) begin
                a_lat[i] <= A[i];
                b_lat[i] <= in_square ? A[i] : B[i];
            end
        end
    end

    mul_row #(
        .NUM_ELEMENTS   (NUM_ELEMENTS),
        .A_BIT_LEN      (A_BIT_LEN),
        .ROWS_PER_CYCLE (ROWS_PER_CYCLE),
        .PASS_W         (PASS_W),
        .MUL_OUT_BIT_LEN(MUL_OUT_BIT_LEN)
    ) u_mul_row (
        .clk    (clk),
        .reset  (reset),
        .in_vld (mul_vld),
        .pass   (pass_q),
        .a      (a_lat),
        .b      (b_lat),
        .vld_p0 (vld_p0),
        .pass_p0(pass_p0),
        .prod_p0(prod_p0)
    );

    // Pass-local column sums, indexed relative to the pass's first row.
    always_comb begin
        for (int m = 0; m < PCOL; m++) begin
            part[m] = '0;
        end
        for (int r = 0; r < ROWS_PER_CYCLE; r++) begin
            for (int j = 0; j < NUM_ELEMENTS; j++) begin
                part[r+j]   = part[r+j]   + ACC_BIT_LEN'(prod_p0[r][j][WORD_LEN-1:0]);
                part[r+j+1] = part[r+j+1] + ACC_BIT_LEN'(prod_p0[r][j][MUL_OUT_BIT_LEN-1:WORD_LEN]);
            end
        end
    end

    always_comb begin
        for (int k = 0; k < NCOL; k++) begin
            acc_d[k] = acc_q[k];
            for (int m = 0; m < PCOL; m++) begin
                if (k == int'(pass_p0) * ROWS_PER_CYCLE + m) begin
                    acc_d[k] = acc_q[k] + part[m];
                end
            end
        end
    end

    // Stage p1: column accumulators, cleared when new operands are taken.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int k = 0; k < NCOL; k++) begin
                acc_q[k] <= '0;
            end
        end else if (vld_p0) begin
            for (int k = 0; k < NCOL; k++) begin
                acc_q[k] <= acc_d[k];
            end
        end
    end

    always_comb begin
        norm[0] = norm_elem(acc_q[0], '0, 1'b0);
        for (int k = 1; k < NCOL; k++) begin
            norm[k] = norm_elem(acc_q[k], acc_q[k-1], 1'(k == NCOL - 1));
        end
    end

    // Stage p2: normalised result held until the downstream handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            for (int k = 0; k < NCOL; k++) begin
                out[k] <= '0;
            end
        end else if (state_q == NORM) begin
            out_valid <= 1'b1;
            for (int k = 0; k < NCOL; k++) begin
                out[k] <= norm[k];
            end
        end else if (state_q == DONE && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
